// File: rtl/regfile_pkg.sv
// Shared constants, register address type and write-qualification helper
// for the register file and its busy scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Address is taken widened so instances with any ADDR_W can share this helper.
    function automatic logic is_effective_write(input logic we, input int unsigned addr,
                                                input logic zero_reg);
        return we && ((addr != 0) || !zero_reg);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight producers, with set/clear/flush
// priority and an incrementally maintained busy counter.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_wa,
    input  logic                    i_set,
    input  logic [ADDR_W-1:0]       i_set_addr,
    input  logic                    i_flush,
    output logic [(2**ADDR_W)-1:0]  o_busy,
    output logic [ADDR_W:0]         o_busy_count
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic [CNT_W-1:0] r_busy_count;
    logic             w_clr;
    logic             w_set;
    logic             w_inc;
    logic             w_dec;

    assign w_clr = is_effective_write(i_we, 32'(i_wa), ZERO_REG != 0);
    assign w_set = i_set && ((i_set_addr != '0) || (ZERO_REG == 0));
    assign w_inc = w_set && !r_busy[i_set_addr];
    // A clear that coincides with a re-set of the same register is not a release.
    assign w_dec = w_clr && r_busy[i_wa] && !(w_set && (i_set_addr == i_wa));

    // NOTE: the vector is defaulted first so every path assigns every bit (no latch).
    always_comb begin
        w_busy_next = r_busy;
        if (w_clr)   w_busy_next[i_wa]       = 1'b0;
        if (w_set)   w_busy_next[i_set_addr] = 1'b1;
        if (i_flush) w_busy_next             = '0;
    end

    // NOTE: non-blocking assignments so both registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (i_flush) begin
                r_busy_count <= '0;
            end else if (w_inc && !w_dec) begin
                r_busy_count <= r_busy_count + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                r_busy_count <= r_busy_count - CNT_W'(1);
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_busy_count = r_busy_count;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional write bypass, optional
// hard-wired zero register and an integrated busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_busy,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_we_eff;

    assign w_we_eff = is_effective_write(we, 32'(wa), ZERO_REG != 0);

    // NOTE: the array is reset because operand fetch relies on every register reading 0 after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we_eff) begin
            r_mem[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_we         (we),
        .i_wa         (wa),
        .i_set        (sb_set),
        .i_set_addr   (sb_set_addr),
        .i_flush      (flush),
        .o_busy       (w_busy),
        .o_busy_count (busy_count)
    );

    // Zero register takes precedence; a bypassed write means the producer has completed.
    always_comb begin
        ra_data = r_mem[ra_addr];
        ra_busy = w_busy[ra_addr];
        if ((ZERO_REG != 0) && (ra_addr == '0)) begin
            ra_data = '0;
            ra_busy = 1'b0;
        end else if ((BYPASS != 0) && w_we_eff && (wa == ra_addr)) begin
            ra_data = wd;
            ra_busy = 1'b0;
        end
    end

    always_comb begin
        rb_data = r_mem[rb_addr];
        rb_busy = w_busy[rb_addr];
        if ((ZERO_REG != 0) && (rb_addr == '0)) begin
            rb_data = '0;
            rb_busy = 1'b0;
        end else if ((BYPASS != 0) && w_we_eff && (wa == rb_addr)) begin
            rb_data = wd;
            rb_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance (zero reg, bypass) and an alternate
// instance (no zero reg, no bypass) share stimulus; expectations go through a queue.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    reg_addr_t   ra_addr, rb_addr, wa, sb_set_addr;
    logic        we, sb_set, flush;
    logic [31:0] wd;
    logic [31:0] ra_data, rb_data, ra_data_alt, rb_data_alt;
    logic        ra_busy, rb_busy, ra_busy_alt, rb_busy_alt;
    logic [5:0]  busy_count, busy_count_alt;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk (clk), .rst (rst),
        .ra_addr (ra_addr), .ra_data (ra_data), .ra_busy (ra_busy),
        .rb_addr (rb_addr), .rb_data (rb_data), .rb_busy (rb_busy),
        .we (we), .wa (wa), .wd (wd),
        .sb_set (sb_set), .sb_set_addr (sb_set_addr), .flush (flush),
        .busy_count (busy_count)
    );

    regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_dut_alt (
        .clk (clk), .rst (rst),
        .ra_addr (ra_addr), .ra_data (ra_data_alt), .ra_busy (ra_busy_alt),
        .rb_addr (rb_addr), .rb_data (rb_data_alt), .rb_busy (rb_busy_alt),
        .we (we), .wa (wa), .wd (wd),
        .sb_set (sb_set), .sb_set_addr (sb_set_addr), .flush (flush),
        .busy_count (busy_count_alt)
    );

    typedef enum int {
        O_RA_DATA, O_RA_BUSY, O_RB_DATA, O_RB_BUSY, O_COUNT,
        O_ALT_RA_DATA, O_ALT_RA_BUSY, O_ALT_RB_DATA, O_ALT_RB_BUSY, O_ALT_COUNT
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_reg  [2][32];
    logic [31:0] m_busy [2];
    int          set_seq [3] = '{7, 9, 7};
    int          cnt_seq [3] = '{1, 2, 2};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input obs_e s);
        case (s)
            O_RA_DATA:     return ra_data;
            O_RA_BUSY:     return 32'(ra_busy);
            O_RB_DATA:     return rb_data;
            O_RB_BUSY:     return 32'(rb_busy);
            O_COUNT:       return 32'(busy_count);
            O_ALT_RA_DATA: return ra_data_alt;
            O_ALT_RA_BUSY: return 32'(ra_busy_alt);
            O_ALT_RB_DATA: return rb_data_alt;
            O_ALT_RB_BUSY: return 32'(rb_busy_alt);
            default:       return 32'(busy_count_alt);
        endcase
    endfunction

    task automatic expect_out(input string t, input obs_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = t;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Reference model: k=0 is the zero-reg/bypass instance, k=1 the alternate.
    function automatic logic m_eff(input int k);
        return we && ((wa != 0) || (k == 1));
    endfunction

    function automatic logic [31:0] m_read(input int k, input reg_addr_t a);
        if (k == 0 && a == 0) return 32'h0;
        if (k == 0 && m_eff(0) && wa == a) return wd;
        return m_reg[k][a];
    endfunction

    function automatic logic m_rbusy(input int k, input reg_addr_t a);
        if (k == 0 && a == 0) return 1'b0;
        if (k == 0 && m_eff(0) && wa == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m_reg[k][i] = 32'h0;
            m_busy[k] = 32'h0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] nb;
            nb = m_busy[k];
            if (m_eff(k)) begin
                m_reg[k][wa] = wd;
                nb[wa] = 1'b0;
            end
            if (sb_set && ((sb_set_addr != 0) || (k == 1))) nb[sb_set_addr] = 1'b1;
            if (flush) nb = 32'h0;
            m_busy[k] = nb;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        sb_set = 1'b0;
        flush = 1'b0;
    endtask

    task automatic expect_model(input string t);
        expect_out({t, ".ra_data"},     O_RA_DATA,     m_read(0, ra_addr));
        expect_out({t, ".ra_busy"},     O_RA_BUSY,     32'(m_rbusy(0, ra_addr)));
        expect_out({t, ".rb_data"},     O_RB_DATA,     m_read(0, rb_addr));
        expect_out({t, ".rb_busy"},     O_RB_BUSY,     32'(m_rbusy(0, rb_addr)));
        expect_out({t, ".count"},       O_COUNT,       32'($countones(m_busy[0])));
        expect_out({t, ".alt_ra_data"}, O_ALT_RA_DATA, m_read(1, ra_addr));
        expect_out({t, ".alt_ra_busy"}, O_ALT_RA_BUSY, 32'(m_rbusy(1, ra_addr)));
        expect_out({t, ".alt_rb_data"}, O_ALT_RB_DATA, m_read(1, rb_addr));
        expect_out({t, ".alt_rb_busy"}, O_ALT_RB_BUSY, 32'(m_rbusy(1, rb_addr)));
        expect_out({t, ".alt_count"},   O_ALT_COUNT,   32'($countones(m_busy[1])));
    endtask

    initial begin
        rst = 1'b0;
        idle();
        wa = '0; wd = '0; sb_set_addr = '0; ra_addr = 5'd5; rb_addr = '0;
        model_reset();
        #1 rst = 1'b1;
        expect_out("rst.ra_data", O_RA_DATA, 32'h0);
        expect_out("rst.count", O_COUNT, 32'h0);
        expect_out("rst.alt_count", O_ALT_COUNT, 32'h0);
        drain();
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle discards data and busy state at once.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; sb_set = 1'b1; sb_set_addr = 5'd5;
        cycle();
        idle();
        expect_out("pre_rst.ra_data", O_RA_DATA, 32'hDEADBEEF);
        expect_out("pre_rst.count", O_COUNT, 32'd1);
        drain();
        rst = 1'b1;
        model_reset();
        expect_out("async_rst.ra_data", O_RA_DATA, 32'h0);
        expect_out("async_rst.ra_busy", O_RA_BUSY, 32'h0);
        expect_out("async_rst.count", O_COUNT, 32'h0);
        expect_out("async_rst.alt_ra_data", O_ALT_RA_DATA, 32'h0);
        expect_out("async_rst.alt_count", O_ALT_COUNT, 32'h0);
        drain();
        #2 rst = 1'b0;
        cycle();

        // Bypass on the default instance, one-cycle latency on the alternate.
        we = 1'b1; wa = 5'd3; wd = 32'h12345678; ra_addr = 5'd3;
        expect_out("byp.ra_data", O_RA_DATA, 32'h12345678);
        expect_out("byp.ra_busy", O_RA_BUSY, 32'h0);
        expect_out("nobyp.old_data", O_ALT_RA_DATA, 32'h0);
        drain();
        cycle();
        idle();
        expect_out("byp.after", O_RA_DATA, 32'h12345678);
        expect_out("nobyp.new_data", O_ALT_RA_DATA, 32'h12345678);
        drain();

        // Register 0: hard-wired on the default instance, ordinary on the alternate.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; sb_set = 1'b1; sb_set_addr = 5'd0; rb_addr = 5'd0;
        expect_out("zero.rb_data_comb", O_RB_DATA, 32'h0);
        expect_out("zero.rb_busy_comb", O_RB_BUSY, 32'h0);
        drain();
        cycle();
        idle();
        expect_out("zero.rb_data", O_RB_DATA, 32'h0);
        expect_out("zero.rb_busy", O_RB_BUSY, 32'h0);
        expect_out("zero.count", O_COUNT, 32'h0);
        expect_out("zero.alt_rb_data", O_ALT_RB_DATA, 32'hFFFFFFFF);
        expect_out("zero.alt_rb_busy", O_ALT_RB_BUSY, 32'h1);
        expect_out("zero.alt_count", O_ALT_COUNT, 32'h1);
        drain();

        // Sets on 7, 9, 7: re-setting a busy register leaves the count alone.
        ra_addr = 5'd7; rb_addr = 5'd9; sb_set = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_set_addr = reg_addr_t'(set_seq[i]);
            cycle();
            expect_out($sformatf("sb.count%0d", i), O_COUNT, 32'(cnt_seq[i]));
            drain();
        end
        idle();
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        cycle();
        idle();
        expect_out("sb.clr_rb_busy", O_RB_BUSY, 32'h0);
        expect_out("sb.clr_ra_busy", O_RA_BUSY, 32'h1);
        expect_out("sb.clr_count", O_COUNT, 32'd1);
        expect_out("sb.clr_rb_data", O_RB_DATA, 32'h99);
        drain();

        // Same-cycle set and clear on register 4: set wins, data still written.
        sb_set = 1'b1; sb_set_addr = 5'd4;
        cycle();
        idle();
        expect_out("sc.count_before", O_COUNT, 32'd2);
        drain();
        we = 1'b1; wa = 5'd4; wd = 32'h44; sb_set = 1'b1; sb_set_addr = 5'd4; ra_addr = 5'd4;
        cycle();
        idle();
        expect_out("sc.ra_busy", O_RA_BUSY, 32'h1);
        expect_out("sc.count", O_COUNT, 32'd2);
        expect_out("sc.ra_data", O_RA_DATA, 32'h44);
        drain();

        // Flush overrides a simultaneous set; the simultaneous write still lands.
        sb_set = 1'b1;
        for (int a = 10; a < 14; a++) begin
            sb_set_addr = reg_addr_t'(a);
            cycle();
        end
        idle();
        expect_out("fl.count_before", O_COUNT, 32'd6);
        drain();
        flush = 1'b1; sb_set = 1'b1; sb_set_addr = 5'd2; we = 1'b1; wa = 5'd1; wd = 32'hA5;
        cycle();
        idle();
        ra_addr = 5'd2; rb_addr = 5'd1;
        expect_out("fl.count", O_COUNT, 32'h0);
        expect_out("fl.ra_busy", O_RA_BUSY, 32'h0);
        expect_out("fl.rb_data", O_RB_DATA, 32'hA5);
        expect_out("fl.alt_count", O_ALT_COUNT, 32'h0);
        drain();

        // Random soak on a narrow address range to force collisions.
        for (int c = 0; c < 600; c++) begin
            we          = 1'($urandom_range(0, 1));
            wa          = reg_addr_t'($urandom_range(0, 7));
            wd          = $urandom;
            sb_set      = ($urandom_range(0, 2) != 0);
            sb_set_addr = reg_addr_t'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 24) == 0);
            ra_addr     = reg_addr_t'($urandom_range(0, 7));
            rb_addr     = reg_addr_t'($urandom_range(0, 7));
            expect_model("soak");
            drain();
            cycle();
        end
        idle();
        expect_model("final");
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
